// File: rtl/lfsr_pattern_gen.sv
// Galois-LFSR test-pattern source for the BIST path: emits NUM_PATTERNS
// N-bit patterns per run under a start / hold / done-ack handshake.
module lfsr_pattern_gen #(
    parameter int          N            = 64,
    parameter int          NUM_PATTERNS = 64,
    parameter logic [63:0] SEED         = 64'h1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         hold_i,
    input  logic         ack_i,
    input  logic         seed_we,
    input  logic [N-1:0] seed_i,
    input  logic [N-1:0] coeff,
    output logic [N-1:0] pattern_o,
    output logic         valid_o,
    output logic         last_o,
    output logic         done_o
);

    localparam int             CW        = $clog2(NUM_PATTERNS) + 1;
    localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(NUM_PATTERNS - 1);
    localparam logic [N-1:0]   LFSR_ZERO = {N{1'b0}};
    localparam logic [N-1:0]   LFSR_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   SEED_T    = N'(SEED);
    localparam logic [N-1:0]   SEED_INIT = (SEED_T == LFSR_ZERO) ? LFSR_ONE : SEED_T;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // An all-zero LFSR state is a lock-up state, so it is never loaded.
    function automatic logic [N-1:0] zero_guard(input logic [N-1:0] v);
        if (v == LFSR_ZERO) begin
            zero_guard = LFSR_ONE;
        end else begin
            zero_guard = v;
        end
    endfunction

    function automatic logic [N-1:0] galois_step(input logic [N-1:0] q,
                                                 input logic [N-1:0] c);
        logic fb;
        fb             = q[N-1];
        galois_step[0] = c[0] & fb;
        for (int k = 1; k < N; k++) begin
            galois_step[k] = q[k-1] ^ (c[k] & fb);
        end
    endfunction

    state_t        state_q, state_d;
    logic [N-1:0]  lfsr_q, lfsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;

    // Next-state, LFSR, counter and output-flag computation.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (seed_we) begin
                    lfsr_d = zero_guard(seed_i);
                end else begin
                    lfsr_d = lfsr_q;
                end
                if (start) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!hold_i) begin
                    lfsr_d = galois_step(lfsr_q, coeff);
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (ack_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Flags are computed from next state so the outputs come straight from flops.
        valid_d = (state_d == S_RUN);
        last_d  = (state_d == S_RUN) && (cnt_d == LAST_CNT);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_INIT;
            cnt_q   <= CNT_ZERO;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign pattern_o = lfsr_q;
    assign valid_o   = valid_q;
    assign last_o    = last_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Self-checking bench for lfsr_pattern_gen: directed scenarios with literal
// expected sequences, then a randomized phase against a behavioural model.
module tb_lfsr_pattern_gen;

    localparam int N  = 4;
    localparam int NP = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         hold_i = 1'b0;
    logic         ack_i = 1'b0;
    logic         seed_we = 1'b0;
    logic [N-1:0] seed_i = 4'h0;
    logic [N-1:0] coeff = 4'b0011;
    logic [N-1:0] pattern_o;
    logic         valid_o;
    logic         last_o;
    logic         done_o;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_pattern_gen #(.N(N), .NUM_PATTERNS(NP), .SEED(64'h1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold_i(hold_i),
        .ack_i(ack_i), .seed_we(seed_we), .seed_i(seed_i), .coeff(coeff),
        .pattern_o(pattern_o), .valid_o(valid_o), .last_o(last_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Multiply by x modulo the feedback polynomial.
    function automatic logic [N-1:0] mul_x(input logic [N-1:0] q, input logic [N-1:0] c);
        logic [N-1:0] r;
        r = q << 1;
        if (q[N-1]) r = r ^ c;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects start already driven; checks NP valid cycles then the done cycle.
    task automatic check_run(input string tag, input logic [N-1:0] exp[NP], input logic [N-1:0] fin);
        for (int i = 0; i < NP; i++) begin
            tick();
            start = 1'b0;
            check_val({tag, "_valid"}, valid_o, 1'b1);
            check_val({tag, "_pat"}, pattern_o, exp[i]);
            check_val({tag, "_last"}, last_o, (i == NP - 1));
            check_val({tag, "_done_lo"}, done_o, 1'b0);
        end
        tick();
        check_val({tag, "_done"}, done_o, 1'b1);
        check_val({tag, "_end_valid"}, valid_o, 1'b0);
        check_val({tag, "_fin"}, pattern_o, fin);
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check_val("ack_done_lo", done_o, 1'b0);
        check_val("ack_valid_lo", valid_o, 1'b0);
    endtask

    logic [N-1:0] seq_a[NP] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6};
    logic [N-1:0] seq_c[NP] = '{4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE};
    logic [N-1:0] seq_9[NP] = '{4'h9, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
    logic [N-1:0] seq_h[8]  = '{4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'h8, 4'h3, 4'h6};

    // Behavioural model for the random phase.
    int           m_mode;   // 0 idle, 1 running, 2 finished
    int           m_emitted;
    logic [N-1:0] m_lfsr;

    initial begin
        // Reset with start held.
        start = 1'b1;
        #12;
        check_val("rst_pat", pattern_o, 4'h1);
        check_val("rst_valid", valid_o, 1'b0);
        check_val("rst_last", last_o, 1'b0);
        check_val("rst_done", done_o, 1'b0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check_val("post_rst_valid", valid_o, 1'b0);
        check_val("post_rst_pat", pattern_o, 4'h1);

        // Basic run.
        start = 1'b1;
        check_run("basic", seq_a, 4'hC);

        // seed_we and start ignored in DONE.
        seed_we = 1'b1; seed_i = 4'h9; start = 1'b1;
        tick();
        seed_we = 1'b0; start = 1'b0;
        check_val("done_seed_ign", pattern_o, 4'hC);
        check_val("done_hold", done_o, 1'b1);
        check_val("done_start_ign", valid_o, 1'b0);
        do_ack();

        // Continuation from retained state.
        start = 1'b1;
        check_run("cont", seq_c, 4'hF);
        do_ack();

        // Zero seed is guarded.
        seed_we = 1'b1; seed_i = 4'h0;
        tick();
        seed_we = 1'b0;
        check_val("seed_zero", pattern_o, 4'h1);

        // Seed + start together; seed_we kept high through the run is ignored.
        seed_we = 1'b1; seed_i = 4'h9; start = 1'b1;
        check_run("seed_start", seq_9, 4'h6);
        seed_we = 1'b0;
        do_ack();

        // Hold for two cycles starting at the 3rd valid cycle.
        seed_we = 1'b1; seed_i = 4'h1;
        tick();
        seed_we = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            check_val("hold_valid", valid_o, 1'b1);
            check_val("hold_pat", pattern_o, seq_h[i]);
            check_val("hold_last", last_o, (i == 7));
            hold_i = (i == 2) || (i == 3);
        end
        tick();
        check_val("hold_done", done_o, 1'b1);
        check_val("hold_fin", pattern_o, 4'hC);
        do_ack();

        // Reset during the 3rd valid cycle.
        seed_we = 1'b1; seed_i = 4'h1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0; seed_we = 1'b0;
            check_val("mid_pat", pattern_o, seq_a[i]);
        end
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", valid_o, 1'b0);
        check_val("mid_rst_pat", pattern_o, 4'h1);
        check_val("mid_rst_last", last_o, 1'b0);
        check_val("mid_rst_done", done_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        check_run("after_rst", seq_a, 4'hC);

        // Randomized phase from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        coeff = 4'b0011;
        m_mode = 0; m_emitted = 0; m_lfsr = 4'h1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            start   = ($urandom_range(0, 3) == 0);
            hold_i  = ($urandom_range(0, 2) == 0);
            ack_i   = ($urandom_range(0, 2) == 0);
            seed_we = ($urandom_range(0, 4) == 0);
            seed_i  = N'($urandom);
            if (m_mode == 0 && $urandom_range(0, 7) == 0) coeff = N'($urandom);
            if (m_mode == 0) begin
                if (seed_we) m_lfsr = (seed_i == 4'h0) ? 4'h1 : seed_i;
                if (start) begin
                    m_mode = 1;
                    m_emitted = 0;
                end
            end else if (m_mode == 1) begin
                if (!hold_i) begin
                    m_lfsr = mul_x(m_lfsr, coeff);
                    m_emitted++;
                    if (m_emitted == NP) m_mode = 2;
                end
            end else begin
                if (ack_i) m_mode = 0;
            end
            tick();
            check_val("rnd_pat", pattern_o, m_lfsr);
            check_val("rnd_valid", valid_o, (m_mode == 1));
            check_val("rnd_last", last_o, (m_mode == 1) && (m_emitted == NP - 1));
            check_val("rnd_done", done_o, (m_mode == 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
